// File: rtl/uart_rx_pkt.sv
// uart_rx_pkt: oversampling UART receiver that deframes DATA_BITS-wide characters
// (LSB first, one start bit, one stop bit) and assembles NUM_BYTES of them into a
// single packet word on rpd, announced by a one-clock rcv_done pulse.
// Framing errors drop the partial packet; an inter-byte idle timeout aborts it.
// Optional even-parity checking: define UART_RX_PKT_PARITY_EN to add the PAR state
// and the par_err output.
module uart_rx_pkt #(
    parameter int DATA_BITS = 8,
    parameter int NUM_BYTES = 4,
    parameter int OVS       = 16,
    parameter int IDLE_TO   = 160
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rxck,
    input  logic                           rxsd,
    output logic                           rcv_done,
    output logic [NUM_BYTES*DATA_BITS-1:0] rpd,
    output logic [$clog2(NUM_BYTES)-1:0]   byte_cnt,
    output logic                           frm_err,
`ifdef UART_RX_PKT_PARITY_EN
    output logic                           par_err,
`endif
    output logic                           pkt_abort
);

    localparam int TW  = $clog2(OVS);
    localparam int IW  = $clog2(IDLE_TO + 1);
    localparam int BCW = $clog2(NUM_BYTES);
    localparam int BW  = $clog2(DATA_BITS);
    localparam int PW  = NUM_BYTES * DATA_BITS;

    localparam logic [TW-1:0]  HALF_LAST = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0]  FULL_LAST = TW'(OVS - 1);
    localparam logic [BW-1:0]  BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BCW-1:0] BYTE_LAST = BCW'(NUM_BYTES - 1);
    localparam logic [IW-1:0]  IDLE_LAST = IW'(IDLE_TO - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3
`ifdef UART_RX_PKT_PARITY_EN
        , S_PAR = 3'd4
`endif
    } state_t;

    state_t                 state_q, state_d;
    logic                   rxsd_meta_q, rxsd_meta_d;
    logic                   rxsd_sync_q, rxsd_sync_d;
    logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [BCW-1:0]         byte_cnt_q, byte_cnt_d;
    logic [IW-1:0]          idle_cnt_q, idle_cnt_d;
    logic [PW-1:0]          rpd_q, rpd_d;
    logic                   rcv_done_q, rcv_done_d;
    logic                   frm_err_q, frm_err_d;
    logic                   pkt_abort_q, pkt_abort_d;
`ifdef UART_RX_PKT_PARITY_EN
    logic                   par_bit_q, par_bit_d;
    logic                   par_err_q, par_err_d;
    logic                   par_smp;
    logic                   par_bad;
`endif

    // Decoded events; every one is qualified by rxck so nothing moves between ticks
    logic          tick_half;
    logic          tick_full;
    logic          start_det;
    logic          start_smp;
    logic          data_smp;
    logic          data_last;
    logic          stop_smp;
    logic          char_ok;
    logic          char_store;
    logic          pkt_complete;
    logic [PW-1:0] pkt_full;

    assign rxsd_meta_d = rxsd;
    assign rxsd_sync_d = rxsd_meta_q;

    assign tick_half = (tick_cnt_q == HALF_LAST);
    assign tick_full = (tick_cnt_q == FULL_LAST);
    assign start_det = rxck && (state_q == S_IDLE) && !rxsd_sync_q;
    assign start_smp = rxck && (state_q == S_START) && tick_half;
    assign data_smp  = rxck && (state_q == S_DATA) && tick_full;
    assign data_last = data_smp && (bit_cnt_q == BIT_LAST);
    assign stop_smp  = rxck && (state_q == S_STOP) && tick_full;

`ifdef UART_RX_PKT_PARITY_EN
    assign par_smp = rxck && (state_q == S_PAR) && tick_full;
    // Even parity: data bits plus parity bit must hold an even number of ones
    assign par_bad = ^{shift_q, par_bit_q};
    assign char_ok = rxsd_sync_q && !par_bad;
`else
    assign char_ok = rxsd_sync_q;
`endif

    assign char_store   = stop_smp && char_ok;
    assign pkt_complete = char_store && (byte_cnt_q == BYTE_LAST);

    // Working buffer: characters 0..NUM_BYTES-2 wait here; the final character is
    // taken straight from the shift register so the whole packet lands in one edge.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BYTES - 1; gi++) begin : g_buf
            logic [DATA_BITS-1:0] char_q, char_d;

            // Capture the received character when it is stored into this slot
            always_comb begin
                char_d = char_q;
                if (char_store && (byte_cnt_q == BCW'(gi))) begin
                    char_d = shift_q;
                end
            end

            // Buffer slot register
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    char_q <= '0;
                end else begin
                    char_q <= char_d;
                end
            end

            assign pkt_full[gi*DATA_BITS +: DATA_BITS] = char_q;
        end
    endgenerate

    assign pkt_full[PW-1 -: DATA_BITS] = shift_q;

    // Two-flop synchroniser for the asynchronous serial line (idles high)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxsd_meta_q <= 1'b1;
            rxsd_sync_q <= 1'b1;
        end else begin
            rxsd_meta_q <= rxsd_meta_d;
            rxsd_sync_q <= rxsd_sync_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic: start detect, start-bit check, data, (parity), stop
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_det) state_d = S_START;
            end
            S_START: begin
                // A high sample at mid start bit is a glitch: return quietly
                if (start_smp) state_d = rxsd_sync_q ? S_IDLE : S_DATA;
            end
            S_DATA: begin
`ifdef UART_RX_PKT_PARITY_EN
                if (data_last) state_d = S_PAR;
`else
                if (data_last) state_d = S_STOP;
`endif
            end
`ifdef UART_RX_PKT_PARITY_EN
            S_PAR: begin
                if (par_smp) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                // Leave at mid stop bit so a following start edge is seen at once
                if (stop_smp) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM output/datapath logic: counters, shifting, packet assembly, pulses
    always_comb begin
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        byte_cnt_d  = byte_cnt_q;
        idle_cnt_d  = '0;
        rpd_d       = rpd_q;
        rcv_done_d  = 1'b0;
        frm_err_d   = 1'b0;
        pkt_abort_d = 1'b0;
`ifdef UART_RX_PKT_PARITY_EN
        par_bit_d   = par_bit_q;
        par_err_d   = 1'b0;
`endif

        // Oversample counter: half bit in START, full bits afterwards
        if (rxck) begin
            case (state_q)
                S_START: tick_cnt_d = tick_half ? '0 : tick_cnt_q + 1'b1;
                S_DATA,
`ifdef UART_RX_PKT_PARITY_EN
                S_PAR,
`endif
                S_STOP:  tick_cnt_d = tick_full ? '0 : tick_cnt_q + 1'b1;
                default: tick_cnt_d = '0;
            endcase
        end

        if (start_smp) begin
            bit_cnt_d = '0;
        end

        // LSB arrives first, so shift right and insert at the top
        if (data_smp) begin
            shift_d   = {rxsd_sync_q, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = data_last ? '0 : bit_cnt_q + 1'b1;
        end

`ifdef UART_RX_PKT_PARITY_EN
        if (par_smp) begin
            par_bit_d = rxsd_sync_q;
        end
`endif

        // Stop-bit sample decides whether the character joins the packet
        if (stop_smp) begin
            frm_err_d = !rxsd_sync_q;
`ifdef UART_RX_PKT_PARITY_EN
            par_err_d = par_bad;
`endif
            if (pkt_complete) begin
                rpd_d      = pkt_full;
                rcv_done_d = 1'b1;
                byte_cnt_d = '0;
            end else if (char_store) begin
                byte_cnt_d = byte_cnt_q + 1'b1;
            end else begin
                byte_cnt_d = '0;
            end
        end

        // Inter-byte timeout; a start edge on the expiry tick takes priority
        if ((state_q == S_IDLE) && (byte_cnt_q != '0)) begin
            idle_cnt_d = idle_cnt_q;
            if (rxck) begin
                if (!rxsd_sync_q) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_LAST) begin
                    idle_cnt_d  = '0;
                    byte_cnt_d  = '0;
                    pkt_abort_d = 1'b1;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            byte_cnt_q  <= '0;
            idle_cnt_q  <= '0;
            rpd_q       <= '0;
            rcv_done_q  <= 1'b0;
            frm_err_q   <= 1'b0;
            pkt_abort_q <= 1'b0;
`ifdef UART_RX_PKT_PARITY_EN
            par_bit_q   <= 1'b0;
            par_err_q   <= 1'b0;
`endif
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            byte_cnt_q  <= byte_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            rpd_q       <= rpd_d;
            rcv_done_q  <= rcv_done_d;
            frm_err_q   <= frm_err_d;
            pkt_abort_q <= pkt_abort_d;
`ifdef UART_RX_PKT_PARITY_EN
            par_bit_q   <= par_bit_d;
            par_err_q   <= par_err_d;
`endif
        end
    end

    assign rcv_done  = rcv_done_q;
    assign rpd       = rpd_q;
    assign byte_cnt  = byte_cnt_q;
    assign frm_err   = frm_err_q;
    assign pkt_abort = pkt_abort_q;
`ifdef UART_RX_PKT_PARITY_EN
    assign par_err   = par_err_q;
`endif

endmodule
